divider: RTL and testbench

Iterative restoring integer divider implementing the RV32M DIV, DIVU, REM and REMU operations. The execute stage hands it two operands and an op code over a valid/ready handshake. It retires one quotient bit per clock and returns the quotient or remainder with a single-cycle `result_valid` pulse. It is the sequential counterpart of the single-cycle adder: repeated trial subtraction replaces one-cycle addition, so the block needs FSM sequencing.

---
 rtl/divider_pkg.sv | 35 +++
 rtl/divider_step.sv | 24 ++
 rtl/divider.sv | 140 ++++++++++++++
 tb/tb_divider.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared execute-unit constants: ALU op codes, divider op codes and FSM states.
package divider_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract divisor.
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        fits    = shifted >= {2'b00, divisor_i};
        diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
        rem_o   = fits ? diff : shifted[WIDTH:0];
        quot_o  = {quot_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             sel_rem_q, sel_rem_d;

    div_op_e          op_in;
    logic             is_signed, is_rem;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, overflow;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] q_fix, r_fix;

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quot_i   (quot_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quot_o   (step_quot)
    );

    always_comb begin
        op_in     = div_op_e'(op);
        is_signed = op_is_signed(op_in);
        is_rem    = op_is_rem(op_in);
        a_neg     = is_signed & operand_a[WIDTH-1];
        b_neg     = is_signed & operand_b[WIDTH-1];
        a_mag     = a_neg ? -operand_a : operand_a;
        b_mag     = b_neg ? -operand_b : operand_b;
        div_zero  = operand_b == '0;
        overflow  = is_signed && (operand_a == MIN_INT) && (&operand_b);
        q_fix     = qneg_q ? -step_quot : step_quot;
        r_fix     = rneg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (div_zero) begin
                        result_d = is_rem ? operand_a : '1;
                        state_d  = S_DONE;
                    end else if (overflow) begin
                        result_d = is_rem ? '0 : operand_a;
                        state_d  = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quot_d    = a_mag;
                        dvs_d     = b_mag;
                        cnt_d     = CNT_INIT;
                        qneg_d    = a_neg ^ b_neg;
                        rneg_d    = a_neg;
                        sel_rem_d = is_rem;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                if (cnt_q == '0) begin
                    // sign fix-up folds into the final iteration's edge
                    result_d = sel_rem_q ? r_fix : q_fix;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quot_q    <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
        end
    end

    assign in_ready     = state_q == S_IDLE;
    assign result_valid = state_q == S_DONE;
    assign result       = result_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed RV32M cases plus random ops vs arithmetic model.
module tb_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        result_valid;

    int tests;
    int fails;

    divider #(
        .WIDTH(32)
    ) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .result      (result),
        .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics straight from the ISA rules
    function automatic logic [31:0] ref_div(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'd0: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            2'd1: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'd2: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Issues one request from idle; lat = n where result_valid is seen in cycle k+n.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
    endtask

    // Runs one op and checks value, latency and the single-cycle pulse.
    task automatic check_op(input string name, input logic [1:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input int exp_lat);
        logic [31:0] r;
        logic [31:0] exp_r;
        int          lat;
        exp_r = ref_div(o, a, b);
        do_op(o, a, b, r, lat);
        tests++;
        if (r !== exp_r) begin
            fails++;
            $display("FAIL %s result: got %h expected %h", name, r, exp_r);
        end
        tests++;
        if (lat !== exp_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        @(posedge clk);
        #1;
        tests++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s pulse: valid %b ready %b expected 0 1",
                     name, result_valid, in_ready);
        end
        tests++;
        if (result !== exp_r) begin
            fails++;
            $display("FAIL %s hold: got %h expected %h", name, result, exp_r);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || result_valid !== 1'b0 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset: ready %b valid %b result %h expected 1 0 0",
                     in_ready, result_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready %b valid %b expected 1 0",
                     in_ready, result_valid);
        end
    endtask

    task automatic test_unsigned;
        check_op("divu_100_7", 2'd1, 32'd100, 32'd7, 33);
        check_op("remu_100_7", 2'd3, 32'd100, 32'd7, 33);
        check_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 33);
        check_op("remu_small", 2'd3, 32'd3, 32'hFFFF_FFFF, 33);
    endtask

    task automatic test_signed;
        check_op("div_m20_3", 2'd0, -32'sd20, 32'd3, 33);
        check_op("rem_m20_3", 2'd2, -32'sd20, 32'd3, 33);
        check_op("div_20_m3", 2'd0, 32'd20, -32'sd3, 33);
        check_op("rem_20_m3", 2'd2, 32'd20, -32'sd3, 33);
        check_op("div_min_2", 2'd0, 32'h8000_0000, 32'd2, 33);
        check_op("rem_min_m7", 2'd2, 32'h8000_0000, -32'sd7, 33);
    endtask

    task automatic test_special;
        check_op("divu_5_0", 2'd1, 32'd5, 32'd0, 1);
        check_op("remu_5_0", 2'd3, 32'd5, 32'd0, 1);
        check_op("div_m5_0", 2'd0, -32'sd5, 32'd0, 1);
        check_op("rem_m5_0", 2'd2, -32'sd5, 32'd0, 1);
        check_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        check_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        check_op("divu_min_m1", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 15));
                1: b = -32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = a >> $urandom_range(0, 31);
                default: ;
            endcase
            if (b == 0) b = 32'd1;
            check_op("random", o, a, b, 33);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1;
        logic [31:0] r2;
        int          busy;
        int          lat2;
        logic        got1;
        got1 = 1'b0;
        r1   = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 2'd1;
        operand_a = 32'd1000;
        operand_b = 32'd9;
        @(posedge clk);
        #1;
        op        = 2'd2;
        operand_a = -32'sd1000;
        operand_b = 32'd7;
        busy = 0;
        while (!in_ready && busy < 100) begin
            if (result_valid) begin
                r1   = result;
                got1 = 1'b1;
            end
            @(posedge clk);
            #1;
            busy++;
        end
        tests++;
        if (busy !== 33) begin
            fails++;
            $display("FAIL b2b_busy: got %0d expected 33", busy);
        end
        tests++;
        if (got1 !== 1'b1 || r1 !== 32'd111) begin
            fails++;
            $display("FAIL b2b_first: got %h (seen %b) expected %h", r1, got1, 32'd111);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: ready %b expected 0", in_ready);
        end
        lat2 = 1;
        while (!result_valid && lat2 < 100) begin
            @(posedge clk);
            #1;
            lat2++;
        end
        r2 = result;
        tests++;
        if (r2 !== ref_div(2'd2, -32'sd1000, 32'd7) || lat2 !== 33) begin
            fails++;
            $display("FAIL b2b_second: got %h lat %0d expected %h lat 33",
                     r2, lat2, ref_div(2'd2, -32'sd1000, 32'd7));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop;
        int          seen;
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 2'd1;
        operand_a = 32'd77777;
        operand_b = 32'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (result !== 32'h0 || result_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset: result %h valid %b ready %b expected 0 0 1",
                     result, result_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (result_valid || result != 0 || !in_ready) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midreset_quiet: %0d bad cycles expected 0", seen);
        end
        do_op(2'd1, 32'd9, 32'd3, r, lat);
        tests++;
        if (r !== 32'd3 || lat !== 33) begin
            fails++;
            $display("FAIL midreset_after: got %h lat %0d expected 3 lat 33", r, lat);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
